branch_resolve_ctrl: RTL and testbench
======================================

BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 Parameter: CNT_W, default 32, width of the statistics counters (legal range 8..32).
REQ-002 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert and active-low; synchronous deassert is provided externally.
REQ-004 Port: in_valid  input  1  branch request valid.
REQ-005 Port: in_ready  output  1  controller can accept a request.
REQ-006 Port: funct3  input  3  RV32I branch funct3.
REQ-007 Port: rs1_val, rs2_val  input  32 each  branch operands.
REQ-008 Port: pc  input  32  branch instruction PC.
REQ-009 Port: imm  input  32  sign-extended B-type offset.
REQ-010 Port: pred_taken  input  1  fetch-stage prediction for this branch.
REQ-011 Port: res_valid  output  1  one-cycle resolution strobe.
REQ-012 Port: res_taken  output  1  resolved direction; qualified by res_valid.
REQ-013 Port: res_mispredict  output  1  resolved direction differs from pred_taken; qualified by res_valid.
REQ-014 Port: illegal  output  1  one-cycle strobe for funct3 010 or 011.
REQ-015 Port: redir_valid  output  1  redirect request to fetch.
REQ-016 Port: redir_ready  input  1  fetch accepts redirect.
REQ-017 Port: redir_pc  output  32  corrected fetch PC.
REQ-018 Port: flush  output  1  equals redir_valid AND redir_ready.
REQ-019 Port: cnt_clr  input  1  synchronous clear of both counters.
REQ-020 Port: br_count  output  CNT_W  resolved legal branches.
REQ-021 Port: mis_count  output  CNT_W  mispredicted branches.

Function
REQ-022 The FSM SHALL have three states: IDLE, EVAL and REDIR.
REQ-023 In IDLE, in_ready SHALL be 1; in EVAL and REDIR, in_ready SHALL be 0.
REQ-024 In IDLE with in_valid=1, the block SHALL register funct3, rs1_val, rs2_val, pc, imm and pred_taken, and go to EVAL.
REQ-025 The registered operands SHALL stay unchanged until the FSM next returns to IDLE.
REQ-026 EVAL SHALL last exactly one cycle and assert res_valid=1 in that cycle.
REQ-027 Direction SHALL be decoded from funct3:
- 000 eq; 001 ne
- 100 signed lt; 101 signed ge
- 110 unsigned lt; 111 unsigned ge
REQ-028 The taken target SHALL be pc+imm and the fall-through SHALL be pc+4, both modulo 2^32 (wrap-around, no trap).
REQ-029 For a legal funct3 in EVAL: res_mispredict = res_taken XOR pred_taken.
- mispredict=1: load redir_pc with the target (if taken) or fall-through (if not), then go to REDIR.
- mispredict=0: go to IDLE.
REQ-030 For an illegal funct3 in EVAL:
- illegal=1, res_taken=0, res_mispredict=0
- no redirect; neither counter changes; next state IDLE
REQ-031 In REDIR, redir_valid SHALL be 1 and redir_pc SHALL be held stable until redir_ready=1. On that cycle flush=1 and the next state is IDLE.
REQ-032 Outside the cases in REQ-026, REQ-030 and REQ-031, res_valid, illegal, redir_valid and flush SHALL be 0.
REQ-033 Latency and throughput:
- a request accepted at edge N gives res_valid in cycle N+1
- the earliest redir_valid is cycle N+2
- minimum initiation interval is 2 cycles without redirect, 3 with a zero-wait redirect.
REQ-034 br_count SHALL increment on every legal EVAL cycle; mis_count SHALL increment on every legal mispredicting EVAL cycle. Both saturate at all-ones.
REQ-035 cnt_clr=1 SHALL zero both counters on the next edge and take priority over a simultaneous increment.
REQ-036 in_valid SHALL be ignored while in_ready=0; no request is queued.

Reset
REQ-037 rst_n=0 SHALL immediately force the following, in any state, including mid-REDIR:
- state IDLE, in_ready=1
- res_valid, res_taken, res_mispredict, illegal, redir_valid, flush = 0
- redir_pc = 0, br_count = 0, mis_count = 0
REQ-038 After rst_n rises, the first in_valid SHALL be accepted in that same cycle if the FSM is in IDLE.

Verification
REQ-039 BNE, rs1=5, rs2=5, pred_taken=1, pc=0x100, imm=0x20, redir_ready=1:
- res_taken=0, res_mispredict=1 at N+1
- redir_pc=0x104 and flush=1 at N+2
- br_count=1, mis_count=1
REQ-040 BLT, rs1=0xFFFFFFFF, rs2=1, pred_taken=1: res_taken=1, no redirect, in_ready=1 at N+2. Same operands with BLTU give taken=0 and mispredict=1.
REQ-041 BEQ taken, pc=0xFFFFFFF0, imm=0x20, pred_taken=0, redir_ready held 0 for 3 cycles:
- redir_pc=0x00000010 stable throughout
- flush only on the accept cycle
- in_valid during the stall is ignored
REQ-042 funct3=011: illegal=1 for one cycle, no redirect, counters unchanged.
REQ-043 With CNT_W=8 and mis_count preloaded to 0xFF by 255 mispredicts, one more mispredict leaves mis_count=0xFF. cnt_clr coincident with a legal EVAL leaves both counters at 0.
REQ-044 rst_n pulled low during REDIR: redir_valid=0 and in_ready=1 without waiting for a clock edge. The counters read 0.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: accepts one RV32I conditional branch, resolves
// its direction one cycle later, and redirects fetch when the prediction was wrong.
// Keeps saturating counts of resolved and mispredicted branches.
module branch_resolve_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [31:0]      rs1_val,
  input  logic [31:0]      rs2_val,
  input  logic [31:0]      pc,
  input  logic [31:0]      imm,
  input  logic             pred_taken,
  output logic             res_valid,
  output logic             res_taken,
  output logic             res_mispredict,
  output logic             illegal,
  output logic             redir_valid,
  input  logic             redir_ready,
  output logic [31:0]      redir_pc,
  output logic             flush,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mis_count
);

  typedef enum logic [1:0] {StIdle, StEval, StRedir} state_e;

  state_e           state_q;
  logic [2:0]       funct3_q;
  logic [31:0]      rs1_q, rs2_q, pc_q, imm_q;
  logic             pred_q;
  logic [31:0]      redir_pc_q;
  logic [CNT_W-1:0] br_q, mis_q;

  logic        is_illegal;
  logic        cond_taken;
  logic        eval_legal;
  logic        eval_mis;
  logic [31:0] target;
  logic [31:0] fallthru;

  // Direction decode and target arithmetic on the captured operands.
  always_comb begin
    cond_taken = 1'b0;
    case (funct3_q)
      3'b000:  cond_taken = (rs1_q == rs2_q);
      3'b001:  cond_taken = (rs1_q != rs2_q);
      3'b100:  cond_taken = ($signed(rs1_q) < $signed(rs2_q));
      3'b101:  cond_taken = ($signed(rs1_q) >= $signed(rs2_q));
      3'b110:  cond_taken = (rs1_q < rs2_q);
      3'b111:  cond_taken = (rs1_q >= rs2_q);
      default: cond_taken = 1'b0;
    endcase
    is_illegal = (funct3_q[2:1] == 2'b01);
    eval_legal = (state_q == StEval) && !is_illegal;
    eval_mis   = eval_legal && (cond_taken ^ pred_q);
    target     = pc_q + imm_q;    // wraps modulo 2^32
    fallthru   = pc_q + 32'd4;
  end

  // Outputs decoded purely from registered state, so no input-to-output paths
  // except flush, which is defined as the redirect handshake itself.
  always_comb begin
    in_ready       = (state_q == StIdle);
    res_valid      = (state_q == StEval);
    res_taken      = eval_legal && cond_taken;
    res_mispredict = eval_mis;
    illegal        = (state_q == StEval) && is_illegal;
    redir_valid    = (state_q == StRedir);
    redir_pc       = redir_pc_q;
    flush          = redir_valid && redir_ready;
    br_count       = br_q;
    mis_count      = mis_q;
  end

  // Control FSM with operand capture and redirect PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      funct3_q   <= 3'b000;
      rs1_q      <= 32'd0;
      rs2_q      <= 32'd0;
      pc_q       <= 32'd0;
      imm_q      <= 32'd0;
      pred_q     <= 1'b0;
      redir_pc_q <= 32'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            funct3_q <= funct3;
            rs1_q    <= rs1_val;
            rs2_q    <= rs2_val;
            pc_q     <= pc;
            imm_q    <= imm;
            pred_q   <= pred_taken;
            state_q  <= StEval;
          end
        end
        StEval: begin
          if (eval_mis) begin
            redir_pc_q <= cond_taken ? target : fallthru;
            state_q    <= StRedir;
          end else begin
            state_q <= StIdle;
          end
        end
        StRedir: begin
          if (redir_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Saturating statistics counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_q  <= '0;
      mis_q <= '0;
    end else if (cnt_clr) begin
      br_q  <= '0;
      mis_q <= '0;
    end else begin
      if (eval_legal && (br_q != '1)) begin
        br_q <= br_q + CNT_W'(1);
      end
      if (eval_mis && (mis_q != '1)) begin
        mis_q <= mis_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_branch_resolve_ctrl;

  localparam int unsigned CW   = 8;
  localparam int unsigned MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    funct3;
  logic [31:0]   rs1_val, rs2_val, pc, imm;
  logic          pred_taken;
  logic          res_valid, res_taken, res_mispredict, illegal;
  logic          redir_valid, redir_ready, flush, cnt_clr;
  logic [31:0]   redir_pc;
  logic [CW-1:0] br_count, mis_count;

  int total = 0;
  int bad   = 0;

  branch_resolve_ctrl #(.CNT_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .funct3         (funct3),
    .rs1_val        (rs1_val),
    .rs2_val        (rs2_val),
    .pc             (pc),
    .imm            (imm),
    .pred_taken     (pred_taken),
    .res_valid      (res_valid),
    .res_taken      (res_taken),
    .res_mispredict (res_mispredict),
    .illegal        (illegal),
    .redir_valid    (redir_valid),
    .redir_ready    (redir_ready),
    .redir_pc       (redir_pc),
    .flush          (flush),
    .cnt_clr        (cnt_clr),
    .br_count       (br_count),
    .mis_count      (mis_count)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = waiting, 1 = resolving, 2 = redirecting.
  int          m_phase;
  logic [2:0]  m_f3;
  logic [31:0] m_a, m_b, m_pc, m_imm, m_redir_pc;
  logic        m_pred;
  int          m_br, m_mis;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic ref_taken(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    int signed sa = a;
    int signed sb = b;
    case (f)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [2:0] f);
    return (f == 3'd2) || (f == 3'd3);
  endfunction

  task automatic model_reset();
    m_phase    = 0;
    m_f3       = 3'd0;
    m_a        = 0;
    m_b        = 0;
    m_pc       = 0;
    m_imm      = 0;
    m_pred     = 0;
    m_redir_pc = 0;
    m_br       = 0;
    m_mis      = 0;
  endtask

  task automatic model_check();
    logic t, il;
    t  = ref_taken(m_f3, m_a, m_b);
    il = ref_illegal(m_f3);
    chk("in_ready", 32'(in_ready), 32'(m_phase == 0));
    chk("res_valid", 32'(res_valid), 32'(m_phase == 1));
    chk("illegal", 32'(illegal), 32'(m_phase == 1 && il));
    if (m_phase == 1) begin
      chk("res_taken", 32'(res_taken), 32'(!il && t));
      chk("res_mispredict", 32'(res_mispredict), 32'(!il && (t != m_pred)));
    end
    chk("redir_valid", 32'(redir_valid), 32'(m_phase == 2));
    if (m_phase == 2) chk("redir_pc", redir_pc, m_redir_pc);
    chk("flush", 32'(flush), 32'(m_phase == 2 && redir_ready));
    chk("br_count", 32'(br_count), 32'(m_br));
    chk("mis_count", 32'(mis_count), 32'(m_mis));
  endtask

  task automatic model_advance();
    logic t, il;
    int   nxt;
    nxt = m_phase;
    if (m_phase == 0) begin
      if (in_valid) begin
        m_f3 = funct3; m_a = rs1_val; m_b = rs2_val;
        m_pc = pc; m_imm = imm; m_pred = pred_taken;
        nxt = 1;
      end
    end else if (m_phase == 1) begin
      t   = ref_taken(m_f3, m_a, m_b);
      il  = ref_illegal(m_f3);
      nxt = 0;
      if (!il) begin
        if (m_br < MAXC) m_br++;
        if (t != m_pred) begin
          if (m_mis < MAXC) m_mis++;
          m_redir_pc = t ? (m_pc + m_imm) : (m_pc + 32'd4);
          nxt = 2;
        end
      end
    end else begin
      if (redir_ready) nxt = 0;
    end
    if (cnt_clr) begin
      m_br  = 0;
      m_mis = 0;
    end
    m_phase = nxt;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance model.
  task automatic step(input logic iv, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] p, input logic [31:0] im,
                      input logic pr, input logic rr, input logic clr);
    @(negedge clk);
    in_valid = iv; funct3 = f3; rs1_val = a; rs2_val = b; pc = p; imm = im;
    pred_taken = pr; redir_ready = rr; cnt_clr = clr;
    #1;
    model_check();
    model_advance();
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, rr, 1'b0);
  endtask

  // Issue one request and let it finish with redir_ready held high (bounded).
  task automatic run_txn(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] im, input logic pr);
    int n;
    step(1'b1, f3, a, b, p, im, pr, 1'b1, 1'b0);
    n = 0;
    while (m_phase != 0 && n < 8) begin
      idle(1'b1);
      n++;
    end
    chk("txn_done", 32'(m_phase), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; funct3 = 0; rs1_val = 0; rs2_val = 0; pc = 0; imm = 0;
    pred_taken = 0; redir_ready = 0; cnt_clr = 0;
    model_reset();
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_redir_valid", 32'(redir_valid), 32'd0);
    chk("rst_redir_pc", redir_pc, 32'd0);
    chk("rst_br_count", 32'(br_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // BNE not taken, predicted taken -> redirect to fall-through.
    step(1'b1, 3'b001, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    chk("bne_taken", 32'(res_taken), 32'd0);
    chk("bne_mis", 32'(res_mispredict), 32'd1);
    idle(1'b1);
    chk("bne_redir_pc", redir_pc, 32'h104);
    chk("bne_flush", 32'(flush), 32'd1);
    idle(1'b0);
    chk("bne_br", 32'(br_count), 32'd1);
    chk("bne_mis_cnt", 32'(mis_count), 32'd1);

    // BLT signed: -1 < 1 taken, correctly predicted.
    step(1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    chk("blt_taken", 32'(res_taken), 32'd1);
    chk("blt_mis", 32'(res_mispredict), 32'd0);
    idle(1'b0);
    chk("blt_ready", 32'(in_ready), 32'd1);
    chk("blt_no_redir", 32'(redir_valid), 32'd0);

    // BLTU: 0xFFFFFFFF < 1 is false -> mispredict.
    step(1'b1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    chk("bltu_taken", 32'(res_taken), 32'd0);
    chk("bltu_mis", 32'(res_mispredict), 32'd1);
    idle(1'b1);
    chk("bltu_redir_pc", redir_pc, 32'h204);
    idle(1'b0);

    // BEQ taken with wrapping target and a stalled redirect.
    step(1'b1, 3'b000, 32'd7, 32'd7, 32'hFFFF_FFF0, 32'h20, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("beq_taken", 32'(res_taken), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'b001, 32'd1, 32'd2, 32'h300, 32'h8, 1'b0, 1'b0, 1'b0);
      chk("stall_redir_pc", redir_pc, 32'h10);
      chk("stall_flush", 32'(flush), 32'd0);
      chk("stall_ready", 32'(in_ready), 32'd0);
    end
    step(1'b1, 3'b001, 32'd1, 32'd2, 32'h300, 32'h8, 1'b0, 1'b1, 1'b0);
    chk("accept_flush", 32'(flush), 32'd1);
    chk("accept_redir_pc", redir_pc, 32'h10);
    idle(1'b0);
    chk("after_stall_ready", 32'(in_ready), 32'd1);
    chk("after_stall_res", 32'(res_valid), 32'd0);

    // Illegal funct3: one-cycle strobe, counters untouched.
    step(1'b1, 3'b011, 32'd1, 32'd1, 32'h400, 32'h10, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    chk("ill_strobe", 32'(illegal), 32'd1);
    idle(1'b1);
    chk("ill_gone", 32'(illegal), 32'd0);
    chk("ill_no_redir", 32'(redir_valid), 32'd0);
    chk("ill_br", 32'(br_count), 32'd4);
    chk("ill_mis", 32'(mis_count), 32'd3);

    // Asynchronous reset while redirecting.
    step(1'b1, 3'b000, 32'd1, 32'd1, 32'h500, 32'h10, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("pre_rst_redir", 32'(redir_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_redir_valid", 32'(redir_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_br", 32'(br_count), 32'd0);
    chk("mid_rst_mis", 32'(mis_count), 32'd0);
    chk("mid_rst_redir_pc", redir_pc, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Saturation of both counters.
    for (int i = 0; i < 255; i++) run_txn(3'b000, 32'd0, 32'd0, 32'h600, 32'h4, 1'b0);
    chk("sat_mis_ff", 32'(mis_count), 32'hFF);
    run_txn(3'b000, 32'd0, 32'd0, 32'h600, 32'h4, 1'b0);
    chk("sat_mis_hold", 32'(mis_count), 32'hFF);
    chk("sat_br_hold", 32'(br_count), 32'hFF);

    // Clear coincident with a legal resolve.
    step(1'b1, 3'b000, 32'd3, 32'd3, 32'h700, 32'h4, 1'b1, 1'b1, 1'b0);
    step(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    chk("clr_br", 32'(br_count), 32'd0);
    chk("clr_mis", 32'(mis_count), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a, b;
      int          sel;
      a   = $urandom;
      sel = $urandom_range(0, 3);
      b   = (sel == 0) ? a : (sel == 1) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
      step(1'($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), a, b, $urandom,
           $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 63) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
